// File: rtl/gpp_dm_arbiter.sv
// rtl/gpp_dm_arbiter.sv - core/host arbiter for the GPP single-port data memory
// Core has priority; host gets bounded bursts and is forced in after a starvation limit.
module gpp_dm_arbiter #(
  parameter int AW           = 9,
  parameter int DW           = 16,
  parameter int MAX_BURST    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_in,
  output logic          dm_w,
  input  logic [DW-1:0] dm_out
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int WW = $clog2(STARVE_LIMIT + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(STARVE_LIMIT - 1);

  typedef enum logic [1:0] {
    S_CORE,
    S_HOST,
    S_YIELD
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [WW-1:0] r_wait_cnt;
  logic [BW-1:0] r_burst_cnt;
  logic          w_enter_host;
  logic          w_leave_host;

  assign core_rdata = dm_out;

  always_comb begin
    w_next     = r_state;
    dm_addr    = core_addr;
    dm_in      = core_wdata;
    dm_w       = core_req & core_we;
    host_gnt   = 1'b0;
    core_stall = 1'b0;
    case (r_state)
      S_CORE: begin
        if (host_req && (!core_req || r_wait_cnt == WAIT_LAST)) begin
          w_next = S_HOST;
        end
      end
      S_HOST: begin
        dm_addr    = host_addr;
        dm_in      = host_wdata;
        dm_w       = host_req & host_we;
        host_gnt   = host_req;
        core_stall = core_req;
        // Dropping the request hands back to the core without a YIELD cycle.
        if (!host_req) begin
          w_next = S_CORE;
        end else if (r_burst_cnt == BURST_LAST) begin
          w_next = S_YIELD;
        end
      end
      S_YIELD: w_next = S_CORE;
      default: w_next = S_CORE;
    endcase
  end

  assign w_enter_host = (r_state != S_HOST) && (w_next == S_HOST);
  assign w_leave_host = (r_state == S_HOST) && (w_next != S_HOST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_CORE;
      r_wait_cnt  <= '0;
      r_burst_cnt <= '0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      r_state <= w_next;

      if (w_enter_host) begin
        r_wait_cnt <= '0;
      end else if (r_state == S_CORE) begin
        if (!host_req) begin
          r_wait_cnt <= '0;
        end else if (core_req && r_wait_cnt != WAIT_LAST) begin
          r_wait_cnt <= r_wait_cnt + WW'(1);
        end
      end

      if (w_leave_host) begin
        r_burst_cnt <= '0;
      end else if (host_gnt) begin
        r_burst_cnt <= r_burst_cnt + BW'(1);
      end

      if (host_gnt && !host_we) begin
        host_rdata  <= dm_out;
        host_rvalid <= 1'b1;
      end else begin
        host_rvalid <= 1'b0;
      end
    end
  end

endmodule
